mux8_rr_scheduler: RTL and testbench
====================================

// Module: mux8_rr_scheduler
// PURPOSE
//  Round-robin scheduler for the 8:1 mux. Shares one mux output F among eight
//  requesters and drives the select lines (A,B,C) of mux8to1.
//  Each requester may hold the mux for a burst of up to MAX_HOLD cycles, then
//  must yield if another requester is pending. Requesters are served fairly in
//  circular order.
// PARAMETERS
//  NREQ      8   number of requesters; fixed at 8 to match mux8to1
//  SEL_W     3   select width, log2(NREQ)
//  MAX_HOLD  4   max consecutive grant cycles while others wait; legal 1..8
//  HOLD_W    3   hold counter width; must hold MAX_HOLD-1
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  reset      in   1      synchronous, active-high reset
//  req        in   8      request per requester; req[i] maps to mux input Di
//  grant      out  8      one-hot grant, registered
//  sel        out  3      binary index of the owner, registered; A=sel[2], B=sel[1], C=sel[0]
//  sel_valid  out  1      1 when grant != 0, i.e. F is driven by an owner
// BEHAVIOUR
//  - Reset values (sync, next edge):
//    grant=0, sel=3'b000, sel_valid=0, state=IDLE, hold_cnt=0, last=3'd7.
//    With last=7, requester 0 has top priority after reset.
//  - Pick function: scan req circularly starting at (base+1) mod 8; the first set
//    bit wins.
//  - Register update on every grant:
//    grant=onehot(k), sel=k, last=k, hold_cnt=0.
//  - IDLE state:
//    * if |req, pick with base=last, then enter GRANT. Latency is 1 cycle from
//      req to grant.
//    * otherwise stay in IDLE. grant=0, sel_valid=0, sel keeps its last value.
//  - GRANT state, owner k. Let others = req with bit k masked off.
//    * req[k]=0 and |others: pick with base=k, stay in GRANT. Handover has no
//      idle bubble.
//    * req[k]=0 and others==0: grant=0, go to IDLE.
//    * req[k]=1, hold_cnt==MAX_HOLD-1 and |others: pick with base=k (rotate).
//    * req[k]=1 otherwise: keep grant. hold_cnt increments and saturates at
//      MAX_HOLD-1. A lone owner is never preempted.
//  - Requests that arrive mid-burst never preempt before the hold limit. They
//    are served in circular order after k.
//  - Reset mid-burst: the next edge restores all reset values regardless of req.
//  - Invariants: grant is one-hot or zero; sel==index(grant) whenever sel_valid=1.
//    Under continuous req, any requester waits at most 7*MAX_HOLD cycles.
// STRUCTURE
//  - Shared header mux8_defs.vh holds:
//    NREQ, SEL_W, and state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
//  - One sub-module, rr_pick8. It is purely combinational: inputs req[7:0] and
//    base[2:0]; outputs found and idx[2:0]. It rotates, priority-encodes, then
//    un-rotates.
//  - The top level holds the FSM, hold counter, last pointer and output registers.
//  - Top-level integration: sel[2:0] drives A,B,C of mux8to1; D0..D7 come from
//    the requesters.
// TESTING (MAX_HOLD=4 unless noted)
//  1. Reset, then req=8'h01.
//     Next edge: grant=8'h01, sel=000, sel_valid=1. F follows D0.
//  2. req=8'hFF held.
//     Grants 0,1,2,...,7,0 in order, each for exactly 4 cycles.
//     Every handover has sel_valid=1 with no gap.
//  3. req=8'h20 held for 12 cycles.
//     grant=8'h20 and sel=101 throughout. No drop or rotation at the hold limit.
//  4. Owner 2 drops req in the same cycle that req[6] rises (req[6] was already
//     pending).
//     Next cycle: grant=8'h40, sel=110. No IDLE cycle.
//  5. reset=1 in the 2nd cycle of a burst by requester 3, then req=8'h81.
//     After reset: grant=0, sel=000, sel_valid=0.
//     Then requester 0 is granted first, and requester 7 after the hold or release.
//  6. Owner 4 releases and req=8'h00.
//     Next cycle: IDLE, grant=0, sel_valid=0, sel stays 100.
//     A later req=8'h11 grants 0 first (base=last=4 scans 5,6,7,0).

Source files
------------

// File: rtl/mux8_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_rr_scheduler_pkg
//  Description : Shared sizes, FSM state encoding and helpers for the 8:1 mux
//                round-robin scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package mux8_rr_scheduler_pkg;

    localparam int NREQ  = 8;   // requesters, one per mux8to1 data input
    localparam int SEL_W = 3;   // log2(NREQ)

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // One-hot vector with bit k set
    function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] k);
        return {{(NREQ-1){1'b0}}, 1'b1} << k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational circular priority picker. Scans req starting
//                at (base+1) mod 8 and returns the first set bit.
//  Ports       : req   [7:0] in  - candidate request vector
//                base  [2:0] in  - index just before the scan start
//                found       out - at least one candidate present
//                idx   [2:0] out - winning index (meaningful when found=1)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick8
    import mux8_rr_scheduler_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] base,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [NREQ-1:0]  w_rot;
    logic [SEL_W-1:0] w_off;

    // Rotate so that bit 0 of w_rot is requester (base+1); 3-bit wrap does the mod 8
    for (genvar i = 0; i < NREQ; i++) begin : g_rot
        assign w_rot[i] = req[SEL_W'(base + SEL_W'(i + 1))];
    end

    // Lowest set bit of the rotated vector wins
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign found = |w_rot;
    // Un-rotate back to an absolute requester index
    assign idx   = SEL_W'(base + w_off + SEL_W'(1));

endmodule
`default_nettype wire

// File: rtl/mux8_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_rr_scheduler
//  Description : Round-robin owner scheduler for a shared 8:1 mux. Each owner
//                may hold the mux up to MAX_HOLD cycles while others wait; a
//                lone owner is never preempted. Outputs are registered.
//  Ports       : clk            in  - rising-edge clock
//                reset          in  - synchronous active-high reset
//                req       [7:0] in  - per-requester request
//                grant     [7:0] out - one-hot grant (or zero)
//                sel       [2:0] out - owner index, drives mux A,B,C
//                sel_valid       out - grant is non-zero
//  Revision    : 1.0  initial release
// ============================================================================
module mux8_rr_scheduler
    import mux8_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 4,   // legal 1..8
    parameter int HOLD_W   = 3    // must hold MAX_HOLD-1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid
);

    localparam logic [HOLD_W-1:0] c_HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  last_q;
    logic              valid_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    logic [NREQ-1:0]   w_cand;
    logic              w_owner_req;
    logic              w_found;
    logic [SEL_W-1:0]  w_idx;
    logic              w_take;
    logic              w_drop;

    // While granted, the current owner is masked out so the scan, which starts
    // at last+1 (= owner+1), only finds other requesters.
    assign w_cand      = (state_q == ST_GRANT) ? (req & ~grant_q) : req;
    assign w_owner_req = |(req & grant_q);

    rr_pick8 u_pick (
        .req   (w_cand),
        .base  (last_q),
        .found (w_found),
        .idx   (w_idx)
    );

    // New grant: from idle, on owner release, or at the hold limit with others waiting
    assign w_take = w_found && ((state_q == ST_IDLE) || !w_owner_req || (hold_q == c_HOLD_LIM));
    // Owner released and nobody else wants the mux
    assign w_drop = (state_q == ST_GRANT) && !w_owner_req && !w_found;

    // Saturating hold counter
    assign hold_d = (hold_q == c_HOLD_LIM) ? hold_q : hold_q + HOLD_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            last_q  <= SEL_W'(NREQ - 1);
        end else if (w_take) begin
            state_q <= ST_GRANT;
            grant_q <= onehot8(w_idx);
            sel_q   <= w_idx;
            last_q  <= w_idx;
            valid_q <= 1'b1;
            hold_q  <= '0;
        end else if (w_drop) begin
            // sel and last keep the departing owner
            state_q <= ST_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else if (state_q == ST_GRANT) begin
            hold_q  <= hold_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign sel_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8_rr_scheduler
//  Description : Self-checking bench for mux8_rr_scheduler: behavioural
//                owner/queue model compared every cycle, plus directed
//                literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux8_rr_scheduler;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       sel_valid;

    int checks = 0;
    int errors = 0;

    mux8_rr_scheduler #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_owner = -1;   // -1 means nobody owns the mux
    int m_sel   = 0;
    int m_last  = 7;
    int m_held  = 0;    // cycles the current owner has held the mux
    bit m_ready = 1'b0;

    function automatic int scan(input int base, input logic [7:0] r);
        for (int s = 1; s <= 8; s++) begin
            if (r[(base + s) % 8]) return (base + s) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [7:0] others;
        int w;
        if (reset) begin
            m_owner = -1; m_sel = 0; m_last = 7; m_held = 0; m_ready = 1'b1;
        end else begin
            others = req;
            if (m_owner >= 0) others[m_owner] = 1'b0;
            w = -1;
            if (m_owner < 0) begin
                if (req != 8'h00) w = scan(m_last, req);
            end else if (!req[m_owner]) begin
                if (others != 8'h00) w = scan(m_owner, others);
                else m_owner = -1;
            end else if (m_held >= MAX_HOLD && others != 8'h00) begin
                w = scan(m_owner, others);
            end else begin
                m_held++;
            end
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_last = w; m_held = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_grant", grant, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
            chk("model_sel", {5'b0, sel}, 8'(m_sel));
            chk("model_valid", {7'b0, sel_valid}, {7'b0, (m_owner >= 0)});
        end
    end

    // Apply inputs, take one rising edge, settle just after it
    task automatic cyc(input logic [7:0] r, input logic rs);
        req = r; reset = rs;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cyc(8'h00, 1'b1);
    endtask

    logic [7:0] pats [6] = '{8'hA5, 8'h5A, 8'h3C, 8'h81, 8'h18, 8'hFE};

    initial begin
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        chk("rst_grant", grant, 8'h00);
        chk("rst_sel", {5'b0, sel}, 8'h00);
        chk("rst_valid", {7'b0, sel_valid}, 8'h00);

        // 1: single requester 0, one-cycle latency
        cyc(8'h01, 1'b0);
        chk("t1_grant", grant, 8'h01);
        chk("t1_sel", {5'b0, sel}, 8'h00);
        chk("t1_valid", {7'b0, sel_valid}, 8'h01);

        // 2: all requesting, 4 cycles each in circular order
        do_reset();
        for (int n = 1; n <= 33; n++) begin
            cyc(8'hFF, 1'b0);
            chk("t2_rr_grant", grant, 8'h01 << (((n - 1) / 4) % 8));
            chk("t2_no_gap", {7'b0, sel_valid}, 8'h01);
        end

        // 3: lone owner never preempted
        do_reset();
        for (int n = 0; n < 12; n++) begin
            cyc(8'h20, 1'b0);
            chk("t3_grant", grant, 8'h20);
            chk("t3_sel", {5'b0, sel}, 8'h05);
        end

        // 4: owner 2 releases with 6 pending, no idle bubble
        do_reset();
        cyc(8'h04, 1'b0);
        chk("t4_own2", grant, 8'h04);
        cyc(8'h44, 1'b0);
        chk("t4_hold2", grant, 8'h04);
        cyc(8'h40, 1'b0);
        chk("t4_hand_grant", grant, 8'h40);
        chk("t4_hand_sel", {5'b0, sel}, 8'h06);

        // 5: reset in the 2nd burst cycle of requester 3
        do_reset();
        cyc(8'h08, 1'b0);
        cyc(8'h08, 1'b0);
        chk("t5_own3", grant, 8'h08);
        cyc(8'h08, 1'b1);
        chk("t5_rst_grant", grant, 8'h00);
        chk("t5_rst_sel", {5'b0, sel}, 8'h00);
        chk("t5_rst_valid", {7'b0, sel_valid}, 8'h00);
        for (int n = 1; n <= 4; n++) begin
            cyc(8'h81, 1'b0);
            chk("t5_first0", grant, 8'h01);
        end
        cyc(8'h81, 1'b0);
        chk("t5_then7", grant, 8'h80);

        // 6: owner 4 releases to idle, later scan starts after 4
        do_reset();
        cyc(8'h10, 1'b0);
        chk("t6_own4", grant, 8'h10);
        cyc(8'h00, 1'b0);
        chk("t6_idle_grant", grant, 8'h00);
        chk("t6_idle_valid", {7'b0, sel_valid}, 8'h00);
        chk("t6_idle_sel", {5'b0, sel}, 8'h04);
        cyc(8'h00, 1'b0);
        cyc(8'h11, 1'b0);
        chk("t6_next0", grant, 8'h01);

        // Mixed patterns, checked by the model each cycle
        do_reset();
        foreach (pats[p]) begin
            for (int n = 0; n < 7; n++) cyc(pats[p], 1'b0);
        end
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
